// File: rtl/fetch_stage.sv
// Instruction fetch stage: a PC register driving a combinational instruction
// memory, feeding a DEPTH-entry FIFO of {instr, pc} pairs toward decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] fetch_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic             push;
    logic             pop;

    // Handshake: an entry transfers to decode on any cycle where dec_valid and
    // dec_ready are both high; dec_valid never looks at dec_ready.
    assign pop  = dec_valid && dec_ready;
    // A full buffer may still accept a fetch when the head leaves the same cycle.
    assign push = !redirect_valid && ((count < FULL) || pop);

    assign icache_addr = pc;
    assign dec_valid   = (count != '0);
    assign dec_instr   = instr_mem[rd_ptr];
    assign dec_pc      = pc_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: buffered entries are dropped, fetch_count is preserved.
            pc     <= {redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= icache_instr;
                pc_mem[wr_ptr]    <= pc;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= pc + 32'd4;
                fetch_count       <= fetch_count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic checked against
// a queue-based model of the fetch buffer.
module tb_fetch_stage;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] fetch_count;

    logic        reset_w;
    logic [31:0] icache_addr_w;
    logic [31:0] icache_instr_w;
    logic        redirect_valid_w;
    logic [31:0] redirect_pc_w;
    logic        dec_valid_w;
    logic        dec_ready_w;
    logic [31:0] dec_instr_w;
    logic [31:0] dec_pc_w;
    logic [31:0] fetch_count_w;

    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fc;
    int          n_pass;
    int          n_total;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h3e800093 + (a >> 2);
    endfunction

    assign icache_instr   = mem_word(icache_addr);
    assign icache_instr_w = mem_word(icache_addr_w);

    fetch_stage #(.RESET_PC(32'h00000000), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .icache_addr(icache_addr), .icache_instr(icache_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFF8), .DEPTH(DEPTH)) dut_w (
        .clock(clock), .reset(reset_w),
        .icache_addr(icache_addr_w), .icache_instr(icache_instr_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .dec_valid(dec_valid_w), .dec_ready(dec_ready_w),
        .dec_instr(dec_instr_w), .dec_pc(dec_pc_w), .fetch_count(fetch_count_w)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver: apply inputs mid-cycle, advance the model, sample 1ns after the edge.
    task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
        logic do_pop;
        logic do_push;
        @(negedge clock);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        if (rst) begin
            exp_q.delete();
            m_pc = 32'h0;
            m_fc = 32'h0;
        end else if (redir) begin
            exp_q.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            do_pop  = (exp_q.size() != 0) && rdy;
            do_push = (exp_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                m_fc = m_fc + 32'd1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h55, 1'b1);
        n_total++;
        if (dec_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dec_valid);
        else n_pass++;
        n_total++;
        if (dec_instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", dec_instr);
        else n_pass++;
        n_total++;
        if (dec_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", dec_pc);
        else n_pass++;
        n_total++;
        if (icache_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", icache_addr);
        else n_pass++;
        n_total++;
        if (fetch_count !== 32'h0) $display("FAIL reset_count: got %h expected 0", fetch_count);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_total++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * k) || dec_instr !== mem_word(32'(4 * k)))
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, dec_valid, dec_pc, dec_instr, 32'(4 * k), mem_word(32'(4 * k)));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_total++;
        if (icache_addr !== 32'h10) $display("FAIL stall_addr: got %h expected 00000010", icache_addr);
        else n_pass++;
        n_total++;
        if (fetch_count !== 32'd4) $display("FAIL stall_count: got %0d expected 4", fetch_count);
        else n_pass++;
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0)
            $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_pc);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_total++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (k + 1)))
                $display("FAIL drain_%0d: got v=%b pc=%h expected v=1 pc=%h",
                         k, dec_valid, dec_pc, 32'(4 * (k + 1)));
            else n_pass++;
        end
    endtask

    task automatic test_full_throughput();
        logic [31:0] prev_fc;
        logic [31:0] prev_pc;
        for (int k = 0; k < 8; k++) begin
            prev_fc = fetch_count;
            prev_pc = dec_pc;
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_total++;
            if (dec_valid !== 1'b1 || fetch_count !== prev_fc + 32'd1 || dec_pc !== prev_pc + 32'd4
                || exp_q.size() != DEPTH || dec_pc !== exp_q[0])
                $display("FAIL full_%0d: got v=%b fc=%0d pc=%h expected v=1 fc=%0d pc=%h",
                         k, dec_valid, fetch_count, dec_pc, prev_fc + 32'd1, prev_pc + 32'd4);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        logic [31:0] saved_fc;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h00000043, 1'b1);
        n_total++;
        if (dec_valid !== 1'b0 || icache_addr !== 32'h40)
            $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=00000040",
                     dec_valid, icache_addr);
        else n_pass++;
        n_total++;
        if (fetch_count !== 32'd3) $display("FAIL redirect_count: got %0d expected 3", fetch_count);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h40 || dec_instr !== mem_word(32'h40))
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h expected v=1 pc=00000040 instr=%h",
                     dec_valid, dec_pc, dec_instr, mem_word(32'h40));
        else n_pass++;
        saved_fc = fetch_count;
        drive(1'b0, 1'b1, 32'h00000100, 1'b1);
        drive(1'b0, 1'b1, 32'h00000207, 1'b1);
        n_total++;
        if (dec_valid !== 1'b0 || icache_addr !== 32'h204 || fetch_count !== saved_fc)
            $display("FAIL redirect_last: got v=%b addr=%h fc=%0d expected v=0 addr=00000204 fc=%0d",
                     dec_valid, icache_addr, fetch_count, saved_fc);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_total++;
        if (dec_pc !== 32'h204) $display("FAIL redirect_last_pc: got %h expected 00000204", dec_pc);
        else n_pass++;
    endtask

    task automatic test_reset_full();
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h00000080, 1'b1);
        n_total++;
        if (dec_valid !== 1'b0 || fetch_count !== 32'h0 || icache_addr !== 32'h0)
            $display("FAIL reset_full: got v=%b fc=%0d addr=%h expected v=0 fc=0 addr=0",
                     dec_valid, fetch_count, icache_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_total++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h0)
            $display("FAIL reset_first_push: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_pc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic rst;
        logic redir;
        int   errs;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            rst   = ($urandom_range(0, 49) == 0);
            redir = ($urandom_range(0, 15) == 0);
            drive(rst, redir, $urandom, 1'($urandom_range(0, 2) != 0));
            n_total++;
            if (dec_valid !== (exp_q.size() != 0) || icache_addr !== m_pc || fetch_count !== m_fc
                || (exp_q.size() != 0 && (dec_pc !== exp_q[0] || dec_instr !== mem_word(exp_q[0])))) begin
                if (errs < 10)
                    $display("FAIL random_%0d: got v=%b pc=%h addr=%h fc=%0d expected v=%b pc=%h addr=%h fc=%0d",
                             k, dec_valid, dec_pc, icache_addr, fetch_count, exp_q.size() != 0,
                             (exp_q.size() != 0) ? exp_q[0] : 32'h0, m_pc, m_fc);
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_exp [4];
        wrap_exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        n_total++;
        if (icache_addr_w !== 32'hFFFFFFF8 || dec_valid_w !== 1'b0)
            $display("FAIL wrap_reset: got addr=%h v=%b expected addr=fffffff8 v=0",
                     icache_addr_w, dec_valid_w);
        else n_pass++;
        @(negedge clock);
        reset_w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            n_total++;
            if (dec_valid_w !== 1'b1 || dec_pc_w !== wrap_exp[k] || dec_instr_w !== mem_word(wrap_exp[k]))
                $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, dec_valid_w, dec_pc_w, dec_instr_w, wrap_exp[k], mem_word(wrap_exp[k]));
            else n_pass++;
        end
    endtask

    initial begin
        n_pass           = 0;
        n_total          = 0;
        m_pc             = 32'h0;
        m_fc             = 32'h0;
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        dec_ready        = 1'b0;
        reset_w          = 1'b1;
        redirect_valid_w = 1'b0;
        redirect_pc_w    = 32'h0;
        dec_ready_w      = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_full_throughput();
        test_redirect();
        test_reset_full();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the byte address fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of fetch-buffer entries (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port icache_addr  output  32  byte address to the instruction memory (word index = addr/4).
REQ-006 SHALL have port icache_instr  input  32  instruction returned combinationally for icache_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; replace the fetch PC.
REQ-008 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-009 SHALL have port dec_valid  output  1  buffer head holds a valid instruction for decode.
REQ-010 SHALL have port dec_ready  input  1  decode accepts the head this cycle.
REQ-011 SHALL have port dec_instr  output  32  instruction at the buffer head.
REQ-012 SHALL have port dec_pc  output  32  byte address of dec_instr.
REQ-013 SHALL have port fetch_count  output  32  running count of instructions pushed into the buffer.

Function
REQ-014 SHALL hold a 32-bit pc register; icache_addr SHALL equal pc combinationally, with pc[1:0] always 2'b00.
REQ-015 SHALL hold a FIFO of DEPTH entries {instr, pc}, with read/write pointers and an occupancy count 0..DEPTH.
REQ-016 pop SHALL occur when dec_valid && dec_ready; dec_valid SHALL equal (count != 0).
REQ-017 push SHALL occur when !redirect_valid && (count < DEPTH || pop); the pushed entry is {icache_instr, pc}.
REQ-018 On push, pc SHALL advance to pc + 4 modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
REQ-019 With no push and no redirect, pc SHALL hold and icache_addr SHALL stay stable.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when count == DEPTH and when count == 0 is impossible to pop.
REQ-021 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be strictly preserved.
REQ-022 dec_instr/dec_pc SHALL be driven from the head entry; a pushed instruction SHALL first appear at dec_instr the cycle after the push (1-cycle fetch-to-decode latency).
REQ-023 On redirect_valid, the next cycle SHALL have count = 0, both pointers = 0, pc = {redirect_pc[31:2], 2'b00}; no push, and any same-cycle pop is discarded with the flush.
REQ-024 Redirect SHALL take priority over push, pop and stall; consecutive redirects each take effect, the last one wins.
REQ-025 fetch_count SHALL increment by 1 on every push, wrap modulo 2^32, and not change on redirect.
REQ-026 dec_valid SHALL not depend combinationally on dec_ready; dec_instr/dec_pc SHALL not depend combinationally on icache_instr.

Reset
REQ-027 While reset is high at a rising edge: pc = RESET_PC & ~32'h3, count = 0, pointers = 0, all buffer entries = 0, fetch_count = 0; reset SHALL override redirect, push and pop.
REQ-028 After reset, dec_valid = 0, dec_instr = 32'h0, dec_pc = 32'h0, icache_addr = RESET_PC & ~32'h3.
REQ-029 Reset asserted mid-stream SHALL discard all buffered instructions; the first push after release SHALL carry pc = RESET_PC.

Verification
REQ-030 Memory word i = 32'h3e800093 + i, dec_ready = 1 after reset -> dec_pc 0,4,8,... consecutive, dec_instr matching word pc/4, one per cycle after the 1-cycle latency.
REQ-031 dec_ready = 0 for 10 cycles -> exactly DEPTH (4) pushes, count = 4, icache_addr frozen at 32'h10, fetch_count = 4; on dec_ready = 1, pc 0x0..0xC drain in order with no gap or duplicate.
REQ-032 Full buffer, dec_ready = 1 -> push and pop each cycle, count stays 4, throughput 1 instruction/cycle.
REQ-033 redirect_valid with redirect_pc = 32'h00000043 while 3 entries buffered -> next cycle dec_valid = 0, icache_addr = 32'h40; the following cycle dec_pc = 32'h40.
REQ-034 RESET_PC = 32'hFFFFFFF8, dec_ready = 1 -> dec_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-035 reset pulsed while full with redirect_valid also high -> next cycle dec_valid = 0, fetch_count = 0, icache_addr = RESET_PC.
